// File: rtl/jtcop_obj_dma.sv
// Object-table DMA: copies the sprite table from shared RAM into the back bank
// of a double buffer; the front bank feeds the line drawer and swaps at vblank.
module jtcop_obj_dma #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          dma_trig,
  output logic          dma_busy,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  input  logic [15:0]   ram_dout,
  input  logic          ram_ok,
  input  logic [AW-1:0] tbl_addr,
  output logic [15:0]   tbl_dout,
  output logic          bank
);

  // state  | meaning
  // IDLE   | no copy running; starts one on trigger or pending request
  // SETTLE | new address presented, ram_ok may still refer to the old one
  // WAIT   | waiting for ram_ok to capture the word into the back bank
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

  state_t      state;
  logic        pending;
  logic        done;
  logic        lvbl_l;
  logic        lvbl_fall;
  logic        wr_en;
  logic [15:0] mem [0:(2**(AW+1))-1];

  assign lvbl_fall = lvbl_l & ~LVBL;
  assign wr_en     = (state == WAIT) && ram_ok;
  assign dma_busy  = (state != IDLE) || pending;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{~bank, ram_addr}] <= ram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tbl_dout <= '0;
    else        tbl_dout <= mem[{bank, tbl_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      done     <= 1'b0;
      lvbl_l   <= 1'b1;
      ram_cs   <= 1'b0;
      ram_addr <= '0;
      bank     <= 1'b0;
    end else begin
      lvbl_l <= LVBL;
      case (state)
        IDLE: begin
          if (pending || dma_trig) begin
            pending  <= 1'b0;
            ram_addr <= '0;
            done     <= 1'b0;
            ram_cs   <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (dma_trig) pending <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (dma_trig) pending <= 1'b1;
          if (ram_ok) begin
            if (&ram_addr) begin
              ram_cs <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              ram_addr <= ram_addr + 1'b1;
              state    <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Swap only with a finished table and nothing queued, so the drawer
      // never switches to a half-written bank.
      if (lvbl_fall && done && (state == IDLE) && !pending) begin
        bank <= ~bank;
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Directed bench for jtcop_obj_dma: table reads are checked through a
// scoreboard queue drained by a monitor; copy timing is checked inline.
module tb_jtcop_obj_dma;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          LVBL = 1'b1;
  logic          dma_trig = 1'b0;
  logic          dma_busy;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_dout;
  logic          ram_ok;
  logic [AW-1:0] tbl_addr = '0;
  logic [15:0]   tbl_dout;
  logic          bank;

  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  t_start = 0;
  int  data_mode = 0;
  logic stall_en = 1'b0;
  int  stall_cnt = 0;
  logic rd_req = 1'b0;
  logic rd_vld_q = 1'b0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;
  exp_t sb_q[$];

  jtcop_obj_dma #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .dma_trig(dma_trig),
    .dma_busy(dma_busy), .ram_cs(ram_cs), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_ok(ram_ok), .tbl_addr(tbl_addr),
    .tbl_dout(tbl_dout), .bank(bank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(int m, int n);
    logic [15:0] v;
    v = 16'(n);
    case (m)
      0:       return v ^ 16'hA5A5;
      1:       return v ^ 16'h5A5A;
      2:       return v + 16'd1;
      default: return v ^ 16'h0F0F;
    endcase
  endfunction

  // Sprite RAM model; ram_ok drops for 7 WAIT cycles on address 100 when stalling
  assign ram_dout = pat(data_mode, int'(ram_addr));
  assign ram_ok = !(stall_en && ram_cs && ram_addr == 10'd100 &&
                    stall_cnt >= 1 && stall_cnt <= 7);

  always @(posedge clk) begin
    if (!stall_en) stall_cnt <= 0;
    else if (ram_cs && ram_addr == 10'd100) stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) rd_vld_q <= rd_req;

  always @(negedge clk) begin
    exp_t e;
    if (rd_vld_q) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk(e.name, 32'(tbl_dout), 32'(e.exp));
      end
    end
  end

  // Address stepping and dwell monitor
  logic          prev_cs = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            dwell = 0;
  always @(negedge clk) begin
    if (ram_cs) begin
      if (!prev_cs) begin
        prev_addr = ram_addr;
        dwell = 1;
      end else if (ram_addr == prev_addr) begin
        dwell++;
      end else begin
        chk("addr_step", 32'(ram_addr), 32'(prev_addr + 10'd1));
        chk("addr_dwell", dwell, (stall_en && prev_addr == 10'd100) ? 9 : 2);
        prev_addr = ram_addr;
        dwell = 1;
      end
    end
    prev_cs = ram_cs;
  end

  task automatic rd(logic [AW-1:0] a, logic [15:0] exp, string name);
    exp_t e;
    @(negedge clk);
    tbl_addr = a;
    rd_req = 1'b1;
    e.name = name;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    dma_trig = 1'b1;
    @(negedge clk);
    dma_trig = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_idle(output int dur);
    int n = 0;
    while (dma_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    dur = cyc - t_start;
  endtask

  task automatic wait_addr(logic [AW-1:0] a, string name);
    int n = 0;
    while (!(ram_cs && ram_addr == a) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(ram_cs && ram_addr == a), 32'd1);
  endtask

  task automatic vblank();
    @(negedge clk);
    LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int dur;
    int act;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_cs", 32'(ram_cs), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_tbl", 32'(tbl_dout), 32'd0);
    chk("rst_bank", 32'(bank), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain copy, then swap at vblank
    data_mode = 0;
    pulse_trig();
    chk("t1_busy_on", 32'(dma_busy), 32'd1);
    wait_idle(dur);
    chk("t1_dur", dur, 2048);
    chk("t1_bank_pre", 32'(bank), 32'd0);
    vblank();
    chk("t1_bank_post", 32'(bank), 32'd1);
    rd(10'd5, 16'hA5A0, "t1_rd5");
    rd(10'd0, pat(0, 0), "t1_rd0");
    rd(10'd1023, pat(0, 1023), "t1_rd1023");

    // ram_ok stall on address 100
    data_mode = 1;
    stall_en = 1'b1;
    pulse_trig();
    wait_idle(dur);
    stall_en = 1'b0;
    chk("t2_dur", dur, 2055);
    vblank();
    chk("t2_bank", 32'(bank), 32'd0);
    rd(10'd99, pat(1, 99), "t2_rd99");
    rd(10'd100, pat(1, 100), "t2_rd100");
    rd(10'd101, pat(1, 101), "t2_rd101");

    // Retrigger at word 300 with new RAM data
    data_mode = 0;
    pulse_trig();
    wait_addr(10'd300, "t3_reach300");
    dma_trig = 1'b1;
    data_mode = 2;
    @(negedge clk);
    dma_trig = 1'b0;
    wait_idle(dur);
    chk("t3_dur", dur, 4097);
    chk("t3_bank_pre", 32'(bank), 32'd0);
    vblank();
    chk("t3_bank_post", 32'(bank), 32'd1);
    rd(10'd0, 16'd1, "t3_rd0");
    rd(10'd299, 16'd300, "t3_rd299");
    rd(10'd300, 16'd301, "t3_rd300");
    rd(10'd1023, 16'd1024, "t3_rd1023");

    // Vblank during a copy must not swap
    data_mode = 1;
    pulse_trig();
    wait_addr(10'd512, "t4_reach512");
    vblank();
    chk("t4_bank_mid", 32'(bank), 32'd1);
    rd(10'd7, 16'd8, "t4_rd7_mid");
    wait_idle(dur);
    chk("t4_bank_done", 32'(bank), 32'd1);
    vblank();
    chk("t4_bank_post", 32'(bank), 32'd0);
    rd(10'd7, pat(1, 7), "t4_rd7_post");

    // Vblank edge on the same cycle as the last word write
    data_mode = 3;
    pulse_trig();
    wait_addr(10'd1023, "t5_reach1023");
    @(negedge clk);
    LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    chk("t5_busy", 32'(dma_busy), 32'd0);
    chk("t5_bank_same", 32'(bank), 32'd0);
    rd(10'd3, pat(1, 3), "t5_rd3_pre");
    vblank();
    chk("t5_bank_next", 32'(bank), 32'd1);
    rd(10'd3, pat(3, 3), "t5_rd3_post");

    // Asynchronous reset mid-copy
    pulse_trig();
    wait_addr(10'd40, "t6_reach40");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cs", 32'(ram_cs), 32'd0);
    chk("t6_busy", 32'(dma_busy), 32'd0);
    chk("t6_bank", 32'(bank), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (10000) begin
      @(negedge clk);
      if (ram_cs || dma_busy) act++;
    end
    chk("t6_quiet", act, 0);
    chk("t6_bank_after", 32'(bank), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtcop_obj_dma.md
Name: jtcop_obj_dma

Overview:
- Object-table DMA and double buffer placed directly upstream of the object line drawer.
- On a CPU trigger it copies the 1024-word sprite table (256 objects × 4 words) from shared sprite RAM into the back bank of an internal double buffer.
- The front bank serves the drawer's table reads through tbl_addr/tbl_dout.
- Banks swap only at vertical-blank start, and only after a complete copy, so the drawer never sees a torn table.

Parameters:
- AW, 10, table address width; copy length is 2^AW words.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- LVBL  in  1  vertical blank, active low; a falling edge marks frame end.
- dma_trig  in  1  one-cycle pulse from the CPU write to the DMA register.
- dma_busy  out  1  high while a copy is in progress or pending.
- ram_cs  out  1  sprite RAM read request.
- ram_addr  out  AW  sprite RAM word address.
- ram_dout  in  16  sprite RAM read data.
- ram_ok  in  1  read data valid.
- tbl_addr  in  AW  drawer read address (front bank).
- tbl_dout  out  16  front-bank data, registered.
- bank  out  1  current front bank index (debug/verification).

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state cleared:
  - dma_busy=0, ram_cs=0, ram_addr=0, tbl_dout=0, bank=0.
  - Internal state: state=IDLE, pending=0, done=0, LVBL edge register=1.
- Buffer: 2×2^AW×16 RAM.
  - Write port: back bank (~bank) at the copy address.
  - Read port: front bank at tbl_addr.
  - tbl_dout updates on the clock edge after tbl_addr is presented (1-cycle latency, every cycle, no enable).
- State machine:
  - IDLE: if pending or dma_trig, then clear pending, set ram_addr=0, done=0, ram_cs=1, and go to SETTLE.
  - SETTLE: hold for one cycle; ram_ok is ignored here because it may be stale from the previous address. Go to WAIT.
  - WAIT: when ram_ok=1, write ram_dout into the back bank at ram_addr.
    - If ram_addr is all ones: ram_cs=0, done=1, go to IDLE.
    - Otherwise: increment ram_addr and go to SETTLE; ram_cs stays 1.
  - ram_addr is held stable for the whole time ram_cs=1 in WAIT.
- Minimum cost is 2 cycles per word; a full copy takes at least 2048 cycles after the trigger is sampled.
- dma_busy = (state != IDLE) | pending.
- Trigger during a copy: pending is set. The current copy finishes, then a new copy restarts from address 0. Multiple triggers collapse into one pending.
- Trigger in the same cycle as the last word is written: pending is set. The machine goes to IDLE and starts the new copy the next cycle.
- Bank swap: on a detected falling edge of LVBL (LVBL register high, LVBL now low):
  - If done=1 and state==IDLE and pending==0, then bank toggles and done clears.
  - Otherwise no swap; done is kept for the next vblank.
- Falling edge of LVBL coinciding with the last-word write: no swap that frame. done is set that cycle and the swap happens at the next vblank.
- A copy in progress across vblank writes only the back bank; front bank contents are unchanged.
- Reset mid-copy: the copy is abandoned, bank returns to 0, and buffer contents are undefined (not cleared).
- Arithmetic: ram_addr is AW bits and wraps only at completion. There is no carry-out use.

Test Plan:
- Reset release, then dma_trig pulse with RAM word n = n^16'hA5A5 and ram_ok always 1. Required: ram_addr steps 0..1023 every 2 cycles, dma_busy high for 2048±2 cycles, bank stays 0 until the next LVBL fall, then bank=1. tbl_addr=5 returns 16'hA5A0 one cycle later.
- ram_ok deasserted for 7 cycles on address 100. Required: ram_addr holds at 100 with ram_cs=1; word 100 is written once; total copy is extended by exactly 7 cycles.
- Second dma_trig at word 300 with RAM contents changed to n+1 after the trigger. Required: first copy completes, second restarts from 0 without dma_busy dropping, and after the swap tbl_dout reads n+1 throughout.
- LVBL falls while a copy is at word 512. Required: no swap, front data unchanged. LVBL falls again after completion: bank toggles.
- LVBL falling edge in the same cycle as the word-1023 write. Required: bank unchanged that frame and toggles at the following LVBL fall.
- rst_n pulled low at word 40. Required: ram_cs, dma_busy and bank go to 0 immediately (asynchronously). After release with no trigger, there is no RAM activity for 10000 cycles.
